cwc_capture_core: RTL and testbench
===================================

// Module: cwc_capture_core
// PURPOSE
//  Parametrised successor capture engine for the ChipWatcher debug path: samples a
//  concatenated probe bus every clk, holds it in a circular sample RAM, and evaluates a
//  masked trigger with edge modes and an occurrence count. Keeps a configurable
//  pre-trigger window and streams the captured window out oldest-first over a
//  valid/ready port toward the debug hub.
// PARAMETERS
//  DATA_W   51    probe bus width (concatenated probes, MSB = first probe)
//  DEPTH    2048  sample RAM depth, power of two, >= 4
//  ADDR_W   $clog2(DEPTH)  derived, not overridable
//  CNT_W    16    trigger occurrence counter width
// PORTS
//  clk         in   1        capture and readout clock
//  rst         in   1        asynchronous, active-high reset
//  probe_din   in   DATA_W   probe bus, sampled every cycle
//  arm         in   1        1-cycle pulse: start a capture (accepted only in IDLE/DONE)
//  abort       in   1        1-cycle pulse: return to IDLE from any state
//  trig_mask   in   DATA_W   1 = bit participates in trigger compare
//  trig_value  in   DATA_W   compare value for masked bits
//  trig_mode   in   2        0 level-eq, 1 rising, 2 falling, 3 any-change
//  trig_count  in   CNT_W    fire on Nth hit; 0 treated as 1
//  pre_depth   in   ADDR_W   samples kept before trigger; clamped to DEPTH-1
//  rd_start    in   1        pulse in DONE: begin readout
//  rd_data     out  DATA_W   sample word
//  rd_valid    out  1        rd_data valid
//  rd_ready    in   1        consumer accepts word
//  rd_last     out  1        with rd_valid: final (DEPTH-th) word
//  state_o     out  3        encoded FSM state (status to hub)
//  triggered   out  1        sticky: trigger fired in this capture
//  trig_addr   out  ADDR_W   RAM address of trigger sample
// BEHAVIOUR
//  - Reset: FSM IDLE; rd_valid, rd_last, triggered = 0; rd_data, trig_addr = 0; counters 0.
//  - Input pipe: probe_din registered once (s0); prior registered sample s1 for edges.
//    Compare: hit_lvl = &(~mask | ~(s0^value)); rise: masked bits ==value in s0 and !=value
//    in s1 (i.e. any masked bit transitions toward value while others match);
//    fall: same with s1==value, s0!=value; change: |(mask & (s0^s1)).
//    First sample after arm: s1 forced = s0, so no edge hit.
//  - States: IDLE(0) -> PRE(1) -> WAIT(2) -> POST(3) -> DONE(4) -> READ(5) -> DONE.
//  - IDLE: no writes. arm -> PRE; wr_ptr=0, pre_cnt=0, hit_cnt=0, triggered=0.
//  - PRE: write s0 each cycle at wr_ptr++ (wraps mod DEPTH). Hits ignored. When
//    pre_cnt == pre_depth -> WAIT (pre_depth=0 -> WAIT on the first cycle after arm).
//  - WAIT: keep writing/wrapping. On hit, hit_cnt++; when hit_cnt+1 == max(trig_count,1):
//    latch trig_addr=wr_ptr (this sample is stored), triggered=1, post_cnt=1 -> POST.
//  - POST: write until post_cnt == DEPTH-pre_depth samples incl. trigger sample -> DONE.
//    Writes stop in DONE; start address rd_base = trig_addr - pre_depth mod DEPTH.
//  - DONE: rd_start -> READ, rd_ptr=rd_base; arm -> new capture (PRE).
//  - READ: DEPTH words, oldest first. RAM read latency 1 cycle; 2-entry skid so rd_valid
//    may hold while rd_ready=0 and rd_data stays stable. Transfer = rd_valid & rd_ready.
//    rd_last asserted with the DEPTH-th word; after its transfer -> DONE (data retained,
//    may be re-read). arm ignored in READ.
//  - abort: any state -> IDLE next cycle, rd_valid=0, skid flushed, triggered cleared.
//    abort and arm same cycle: abort wins. rd_start outside DONE ignored.
//  - trig_* and pre_depth sampled at arm into shadow regs; later changes have no effect.
//  - rst asserted mid-capture or mid-readout: immediate return to reset values; RAM
//    contents undefined, never read before a new capture completes.
// STRUCTURE
//  - Package cwc_capture_pkg: state enum (3-bit), trig_mode enum, TRIG_* constants.
//  - Sub-module cwc_sample_ram: simple dual-port RAM, 1 write/1 read port, 1-cycle read
//    latency, no reset on array (maps to block RAM).
//  - Trigger compare, FSM, pointer/counter logic and readout skid stay in this module.
// TESTING
//  - DEPTH=16, pre_depth=4, level, mask=all, value=0x2A; ramp 0,1,2.. -> triggered, words
//    0x26..0x35 streamed, rd_last on 16th, trig_addr consistent.
//  - Rising mode, mask bit0, count=3, toggling bit0 -> trigger on 3rd 0->1, not on level.
//  - Trigger value present during PRE and first cycle after arm -> ignored; fires later.
//  - pre_depth=0 and pre_depth=DEPTH-1 (clamped, 1 post sample) -> correct word order.
//  - rd_ready random 50% backpressure -> no drop/duplicate, rd_data stable while stalled.
//  - abort in WAIT and READ, rst in POST -> IDLE, rd_valid=0; re-arm captures cleanly.

Source files
------------

// File: rtl/cwc_capture_pkg.sv
// rtl/cwc_capture_pkg.sv - shared types for the capture engine
package cwc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4,
    ST_READ = 3'd5
  } cwc_state_t;

  typedef enum logic [1:0] {
    TRIG_LEVEL  = 2'd0,
    TRIG_RISE   = 2'd1,
    TRIG_FALL   = 2'd2,
    TRIG_CHANGE = 2'd3
  } trig_mode_t;

  localparam int TRIG_MODE_W = 2;

endpackage

// File: rtl/cwc_capture_if.sv
// rtl/cwc_capture_if.sv - readout stream toward the debug hub
interface cwc_capture_if #(
  parameter int DATA_W = 51
);
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/cwc_sample_ram.sv
// rtl/cwc_sample_ram.sv - simple dual-port sample RAM, 1-cycle read latency
module cwc_sample_ram #(
  parameter int DATA_W = 51,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_q <= mem[rd_addr];
  end
endmodule

// File: rtl/cwc_capture_core.sv
// rtl/cwc_capture_core.sv - probe capture with masked/edge trigger and pre-trigger window
module cwc_capture_core
  import cwc_capture_pkg::*;
#(
  parameter int  DATA_W = 51,
  parameter int  DEPTH  = 2048,
  parameter int  CNT_W  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] probe_din,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [1:0]        trig_mode,
  input  logic [CNT_W-1:0]  trig_count,
  input  logic [ADDR_W-1:0] pre_depth,
  input  logic              rd_start,
  cwc_capture_if.master     rd_if,
  output logic [2:0]        state_o,
  output logic              triggered,
  output logic [ADDR_W-1:0] trig_addr
);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  cwc_state_t        state, state_nx;
  trig_mode_t        sh_mode;
  logic [DATA_W-1:0] s0, s1, s1_eff, sh_mask, sh_value, sk0, sk1, ram_q;
  logic [CNT_W-1:0]  sh_count, hit_cnt, hit_tgt;
  logic [ADDR_W-1:0] sh_pre, wr_ptr, pre_cnt, rd_ptr, rd_base;
  logic [ADDR_W:0]   post_cnt, post_tgt, rd_issued;
  logic [1:0]        sk_cnt, occ;
  logic first, eq0, eq1, hit, fire, we, arm_ok, re, pop;
  logic inflight, inflight_last, sk0_last, sk1_last;

  // The first sample after arm has no valid predecessor, so edges cannot fire on it.
  assign s1_eff   = first ? s0 : s1;
  assign eq0      = &(~sh_mask | ~(s0 ^ sh_value));
  assign eq1      = &(~sh_mask | ~(s1_eff ^ sh_value));
  assign hit_tgt  = (sh_count == '0) ? CNT_W'(1) : sh_count;
  assign post_tgt = DEPTH_W - {1'b0, sh_pre};
  assign rd_base  = trig_addr - sh_pre;
  assign arm_ok   = arm & ((state == ST_IDLE) | (state == ST_DONE));
  assign pop      = rd_if.rd_valid & rd_if.rd_ready;

  always_comb begin
    hit = 1'b0;
    case (sh_mode)
      TRIG_LEVEL:  hit = eq0;
      TRIG_RISE:   hit = eq0 & ~eq1;
      TRIG_FALL:   hit = eq1 & ~eq0;
      TRIG_CHANGE: hit = |(sh_mask & (s0 ^ s1_eff));
      default:     hit = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    we       = 1'b0;
    fire     = 1'b0;
    case (state)
      ST_IDLE: if (arm) state_nx = ST_PRE;
      ST_PRE: begin
        we = 1'b1;
        if (pre_cnt == sh_pre) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        we = 1'b1;
        if (hit && (hit_cnt + CNT_W'(1) == hit_tgt)) begin
          fire     = 1'b1;
          state_nx = ST_POST;
        end
      end
      ST_POST: begin
        if (post_cnt == post_tgt) state_nx = ST_DONE;
        else                      we = 1'b1;
      end
      ST_DONE: begin
        if (arm)           state_nx = ST_PRE;
        else if (rd_start) state_nx = ST_READ;
      end
      ST_READ: if (pop && sk0_last) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      s0        <= '0;
      s1        <= '0;
      first     <= 1'b0;
      sh_mode   <= TRIG_LEVEL;
      sh_mask   <= '0;
      sh_value  <= '0;
      sh_count  <= '0;
      sh_pre    <= '0;
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      hit_cnt   <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      trig_addr <= '0;
    end else begin
      state <= state_nx;
      s0    <= probe_din;
      s1    <= s0;
      first <= 1'b0;
      if (we) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (state == ST_PRE) pre_cnt <= pre_cnt + ADDR_W'(1);
      if (state == ST_WAIT && hit) hit_cnt <= hit_cnt + CNT_W'(1);
      if (state == ST_POST && we) post_cnt <= post_cnt + (ADDR_W+1)'(1);
      if (fire) begin
        trig_addr <= wr_ptr;
        triggered <= 1'b1;
        post_cnt  <= (ADDR_W+1)'(1);
      end
      if (arm_ok && !abort) begin
        sh_mode   <= trig_mode_t'(trig_mode);
        sh_mask   <= trig_mask;
        sh_value  <= trig_value;
        sh_count  <= trig_count;
        sh_pre    <= pre_depth;
        wr_ptr    <= '0;
        pre_cnt   <= '0;
        hit_cnt   <= '0;
        triggered <= 1'b0;
        first     <= 1'b1;
      end
      if (abort) triggered <= 1'b0;
    end
  end

  cwc_sample_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (s0),
    .re      (re),
    .rd_addr (rd_ptr),
    .rd_q    (ram_q)
  );

  // Only issue a read when the skid can absorb it even if the consumer stalls.
  assign occ = sk_cnt + {1'b0, inflight} - {1'b0, pop};
  assign re  = (state == ST_READ) && (rd_issued != DEPTH_W) && (occ < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      rd_issued     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      sk0           <= '0;
      sk1           <= '0;
      sk0_last      <= 1'b0;
      sk1_last      <= 1'b0;
      sk_cnt        <= '0;
    end else begin
      inflight      <= re;
      inflight_last <= re && (rd_issued == DEPTH_W - (ADDR_W+1)'(1));
      if (re) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        rd_issued <= rd_issued + (ADDR_W+1)'(1);
      end
      if (pop && sk_cnt == 2'd2) begin
        sk0      <= sk1;
        sk0_last <= sk1_last;
      end
      if (inflight) begin
        if (sk_cnt == 2'd0 || (sk_cnt == 2'd1 && pop)) begin
          sk0      <= ram_q;
          sk0_last <= inflight_last;
        end else begin
          sk1      <= ram_q;
          sk1_last <= inflight_last;
        end
      end
      sk_cnt <= occ;
      if (state == ST_DONE && state_nx == ST_READ) begin
        rd_ptr    <= rd_base;
        rd_issued <= '0;
      end
      if (abort) begin
        inflight <= 1'b0;
        sk_cnt   <= '0;
      end
    end
  end

  assign rd_if.rd_data  = sk0;
  assign rd_if.rd_valid = (sk_cnt != 2'd0);
  assign rd_if.rd_last  = rd_if.rd_valid & sk0_last;
  assign state_o        = state;
endmodule

// File: tb/tb_cwc_capture_core.sv
// tb/tb_cwc_capture_core.sv - directed scoreboard bench for cwc_capture_core
module tb_cwc_capture_core;
  localparam int DW = 51;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] probe_din, trig_mask, trig_value;
  logic          arm, abort, rd_start;
  logic [1:0]    trig_mode;
  logic [15:0]   trig_count;
  logic [3:0]    pre_depth;
  logic [2:0]    state_o;
  logic          triggered;
  logic [3:0]    trig_addr;

  cwc_capture_if #(.DATA_W(DW)) rd_if ();

  cwc_capture_core #(.DATA_W(DW), .DEPTH(DP), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .probe_din  (probe_din),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_mode  (trig_mode),
    .trig_count (trig_count),
    .pre_depth  (pre_depth),
    .rd_start   (rd_start),
    .rd_if      (rd_if),
    .state_o    (state_o),
    .triggered  (triggered),
    .trig_addr  (trig_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int kind   = 0;
  int seq    = 0;
  logic [DW-1:0] exp_q [$];
  localparam logic [DW-1:0] ALL = {DW{1'b1}};

  function automatic logic [DW-1:0] pat(input int k, input int s);
    logic [DW-1:0] v;
    case (k)
      1:       v = (DW'(s) << 1) | DW'((s < 20) ? 1 : (s & 1));
      2:       v = (DW'(s) << 8) | ((s <= 3 || s == 10) ? DW'('h55) : DW'(0));
      default: v = DW'(s);
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    seq++;
    probe_din = pat(kind, seq);
  endtask

  task automatic push_window(input int k, input int t, input int pre);
    for (int i = 0; i < DP; i++) exp_q.push_back(pat(k, t - pre + i));
  endtask

  task automatic start_cap(input int k, input logic [DW-1:0] m, input logic [DW-1:0] v,
                           input logic [1:0] md, input logic [15:0] cnt, input logic [3:0] pre);
    kind       = k;
    seq        = 0;
    probe_din  = pat(k, 0);
    trig_mask  = m;
    trig_value = v;
    trig_mode  = md;
    trig_count = cnt;
    pre_depth  = pre;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    trig_value = ~v;
    trig_mode  = ~md;
    trig_count = cnt + 16'd5;
    pre_depth  = ~pre;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (state_o == st) found = 1'b1;
      tick();
    end
    chk("wait_state", 64'(found), 64'd1);
  endtask

  task automatic run_read(input bit bp);
    int got = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] expv;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (got < DP && cyc < 400) begin
      rd_if.rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stall) begin
        chk("stall_valid", 64'(rd_if.rd_valid), 64'd1);
        chk("stall_data", 64'(rd_if.rd_data), 64'(held));
      end
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("rd_data", 64'(rd_if.rd_data), 64'(expv));
        chk("rd_last", 64'(rd_if.rd_last), 64'(got == DP - 1));
        got++;
        stall = 1'b0;
      end else begin
        stall = rd_if.rd_valid;
        held  = rd_if.rd_data;
      end
      tick();
      cyc++;
    end
    rd_if.rd_ready = 1'b0;
    chk("read_count", 64'(got), 64'(DP));
    @(negedge clk);
    chk("read_done_state", 64'(state_o), 64'(4));
    chk("read_valid_low", 64'(rd_if.rd_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_start = 1'b0; rd_if.rd_ready = 1'b0;
    probe_din = '0; trig_mask = '0; trig_value = '0; trig_mode = 2'd0;
    trig_count = '0; pre_depth = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_valid", 64'(rd_if.rd_valid), 64'd0);
    chk("rst_last", 64'(rd_if.rd_last), 64'd0);
    chk("rst_trig", 64'(triggered), 64'd0);
    chk("rst_taddr", 64'(trig_addr), 64'd0);
    chk("rst_data", 64'(rd_if.rd_data), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // level ramp, count 0 behaves as 1, then re-read under backpressure
    start_cap(0, ALL, DW'('h2A), 2'd0, 16'd0, 4'd4);
    push_window(0, 42, 4);
    wait_state(3'd4, 120);
    chk("t1_trig", 64'(triggered), 64'd1);
    chk("t1_taddr", 64'(trig_addr), 64'd10);
    run_read(1'b0);
    push_window(0, 42, 4);
    run_read(1'b1);

    // rising edge on bit0, third occurrence, long high level in between
    start_cap(1, DW'(1), DW'(1), 2'd1, 16'd3, 4'd2);
    push_window(1, 25, 2);
    wait_state(3'd4, 120);
    chk("t2_taddr", 64'(trig_addr), 64'd9);
    run_read(1'b1);

    // value present during PRE must not fire
    start_cap(2, DW'('hFF), DW'('h55), 2'd0, 16'd1, 4'd3);
    push_window(2, 10, 3);
    wait_state(3'd4, 120);
    chk("t3_taddr", 64'(trig_addr), 64'd10);
    run_read(1'b0);

    // pre_depth 0
    start_cap(0, ALL, DW'(5), 2'd0, 16'd1, 4'd0);
    push_window(0, 5, 0);
    wait_state(3'd4, 120);
    chk("t4_taddr", 64'(trig_addr), 64'd5);
    run_read(1'b0);

    // abort during READ; arm in READ ignored
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("rdab_valid", 64'(rd_if.rd_valid), 64'd1);
    chk("rdab_data", 64'(rd_if.rd_data), 64'(pat(0, 5)));
    chk("rdab_state", 64'(state_o), 64'd5);
    arm = 1'b1; tick(); arm = 1'b0;
    @(negedge clk);
    chk("arm_in_read", 64'(state_o), 64'd5);
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    chk("rdab_idle", 64'(state_o), 64'd0);
    chk("rdab_vlow", 64'(rd_if.rd_valid), 64'd0);
    chk("rdab_trig", 64'(triggered), 64'd0);
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    @(negedge clk);
    chk("rdstart_idle", 64'(state_o), 64'd0);

    // pre_depth DEPTH-1: trigger sample is the only post sample
    start_cap(0, ALL, DW'(20), 2'd0, 16'd1, 4'd15);
    push_window(0, 20, 15);
    wait_state(3'd4, 120);
    chk("t5_taddr", 64'(trig_addr), 64'd4);
    run_read(1'b1);

    // arm and abort together: abort wins
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("arm_abort", 64'(state_o), 64'd0);

    // abort while waiting
    start_cap(0, ALL, DW'('h10000), 2'd0, 16'd1, 4'd2);
    repeat (8) tick();
    @(negedge clk);
    chk("wait_state_seen", 64'(state_o), 64'd2);
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    chk("wait_abort", 64'(state_o), 64'd0);

    // reset during POST, then a clean capture
    start_cap(0, ALL, DW'(10), 2'd0, 16'd1, 4'd4);
    wait_state(3'd3, 60);
    chk("post_trig", 64'(triggered), 64'd1);
    rst = 1'b1;
    #1;
    chk("post_rst_state", 64'(state_o), 64'd0);
    chk("post_rst_trig", 64'(triggered), 64'd0);
    chk("post_rst_taddr", 64'(trig_addr), 64'd0);
    chk("post_rst_valid", 64'(rd_if.rd_valid), 64'd0);
    tick();
    rst = 1'b0;
    start_cap(0, ALL, DW'(30), 2'd0, 16'd1, 4'd4);
    push_window(0, 30, 4);
    wait_state(3'd4, 120);
    chk("t8_taddr", 64'(trig_addr), 64'd14);
    run_read(1'b0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
